// File: rtl/mbe_mac_acc.sv
// mbe_mac_acc: accumulates NTAPS signed MBE products into one FIR sample.
// Optional MBE_MAC_SAT_EN: saturate accumulator and sample on overflow.
module mbe_mac_acc #(
  parameter int DWIDTH = 11,
  parameter int NTAPS  = 9,
  parameter int GUARD  = 4,
  localparam int PW    = 2*DWIDTH,
  localparam int AW    = PW + GUARD
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 prod_valid_i,
  input  logic signed [PW-1:0] prod_i,
  output logic                 prod_ready_o,
  output logic                 sum_valid_o,
  input  logic                 sum_ready_i,
  output logic signed [AW-1:0] sum_o,
  output logic                 ovf_o
);

  localparam int CW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NTAPS-1);

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf_acc;
  logic [AW-1:0]   r_sum;
  logic            r_valid;
  logic            r_ovf;

  logic            w_take;
  logic            w_drain;
  logic            w_first;
  logic            w_last;
  logic [AW-1:0]   w_ext;
  logic [AW-1:0]   w_a;
  logic [AW-1:0]   w_sum;
  logic            w_ovf;
  logic            w_ovf_fin;
  logic [AW-1:0]   w_res;
  logic [AW-1:0]   w_fin;

  assign prod_ready_o = (r_state == S_ACC) | sum_ready_i;
  assign sum_valid_o  = r_valid;
  assign sum_o        = r_sum;
  assign ovf_o        = r_ovf;

  assign w_take  = prod_valid_i & prod_ready_o;
  assign w_drain = r_valid & sum_ready_i;
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LAST);

  assign w_ext   = AW'(prod_i);
  assign w_a     = w_first ? '0 : r_acc;
  assign w_sum   = w_a + w_ext;
  assign w_ovf   = (w_a[AW-1] == w_ext[AW-1]) &
                   (w_sum[AW-1] != w_a[AW-1]);
  assign w_ovf_fin = r_ovf_acc | w_ovf;

`ifdef MBE_MAC_SAT_EN
  localparam logic [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};

  // Direction of the most recent overflow in this frame
  logic            r_neg;
  logic            w_neg;
  logic [AW-1:0]   w_clamp;

  assign w_neg   = w_ovf ? w_a[AW-1] : r_neg;
  assign w_clamp = w_neg ? MINV : MAXV;
  assign w_res   = w_ovf ? w_clamp : w_sum;
  assign w_fin   = w_ovf_fin ? w_clamp : w_sum;
`else
  assign w_res   = w_sum;
  assign w_fin   = w_sum;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_sum     <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
`ifdef MBE_MAC_SAT_EN
      r_neg     <= 1'b0;
`endif
    end else if (clear_i) begin
      r_state   <= S_ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_drain) begin
        r_valid <= 1'b0;
        r_state <= S_ACC;
      end
      // In HOLD an accept implies a drain, and cnt is 0 there
      if (w_take) begin
        if (w_last) begin
          r_sum     <= w_fin;
          r_ovf     <= w_ovf_fin;
          r_valid   <= 1'b1;
          r_acc     <= w_res;
          r_cnt     <= '0;
          r_ovf_acc <= 1'b0;
          r_state   <= S_HOLD;
        end else begin
          r_acc     <= w_res;
          r_cnt     <= r_cnt + 1'b1;
          r_ovf_acc <= w_ovf_fin;
`ifdef MBE_MAC_SAT_EN
          r_neg     <= w_neg;
`endif
        end
      end
    end
  end

endmodule
